// File: rtl/knn_batch_sched.sv
// KNN batch scheduler: queues test points, walks the data-point memory per job, reports completion.
// Latency: job start one cycle after IDLE sees a queued point; issues trail memory reads by one cycle.
// Backpressure: tp_ready_o low while the queue is full; REPORT holds until res_ready_i.
module knn_batch_sched #(
  parameter int DATA_W     = 32,
  parameter int MAX_PTS    = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64,
  localparam int PTS_W     = $clog2(MAX_PTS + 1),
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic [PTS_W-1:0]  num_pts_i,
  input  logic              tp_valid_i,
  input  logic [DATA_W-1:0] tp_data_i,
  output logic              tp_ready_o,
  output logic              dp_rd_o,
  output logic [PTS_W-1:0]  dp_addr_o,
  input  logic [DATA_W-1:0] dp_data_i,
  output logic              dist_start_o,
  output logic [DATA_W-1:0] dist_test_o,
  output logic [DATA_W-1:0] dist_data_o,
  output logic              dist_last_o,
  input  logic              dist_done_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [7:0]        res_tag_o,
  output logic              res_err_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  fifo_cnt_o
);

  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, REPORT} state_t;

  state_t state, nxt;

  // Queue storage and bookkeeping; each entry is {tag, test point}.
  logic [DATA_W+7:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic [7:0]        tag_cnt;
  logic              push, pop, full, empty;
  logic [DATA_W+7:0] head;

  // Job context.
  logic [DATA_W-1:0] test_r;
  logic [7:0]        tag_r;
  logic [PTS_W-1:0]  n_r, idx;
  logic [WD_W-1:0]   wd;
  logic              err_r, dist_start_r, last_r;
  logic              dp_rd, range_ok, last_idx;

  assign full     = (cnt == CNT_W'(FIFO_DEPTH));
  assign empty    = (cnt == '0);
  assign push     = tp_valid_i && !full;
  assign head     = fifo_mem[rd_ptr];
  assign range_ok = (num_pts_i >= PTS_W'(1)) && (num_pts_i <= PTS_W'(MAX_PTS));
  assign last_idx = (idx == n_r - PTS_W'(1));

  // Queue payload write; no reset needed on data.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {tag_cnt, tp_data_i};
  end

  // Queue pointers, occupancy and tag counter; simultaneous push and pop both take effect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      tag_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + AW'(1);
        tag_cnt <= tag_cnt + 8'd1;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next-state and per-cycle controls; done wins over a same-cycle watchdog expiry.
  always_comb begin
    nxt   = state;
    pop   = 1'b0;
    dp_rd = 1'b0;
    case (state)
      IDLE: begin
        if (en_i && !empty) begin
          pop = 1'b1;
          nxt = range_ok ? ISSUE : REPORT;
        end
      end
      ISSUE: begin
        dp_rd = 1'b1;
        if (last_idx) nxt = DRAIN;
      end
      DRAIN: begin
        if (dist_done_i || (wd == WD_W'(TIMEOUT - 1))) nxt = REPORT;
      end
      REPORT: begin
        if (res_ready_i) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Job context, read index, watchdog and the one-cycle issue pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      test_r       <= '0;
      tag_r        <= '0;
      n_r          <= '0;
      idx          <= '0;
      wd           <= '0;
      err_r        <= 1'b0;
      dist_start_r <= 1'b0;
      last_r       <= 1'b0;
    end else begin
      if (pop) begin
        test_r <= head[DATA_W-1:0];
        tag_r  <= head[DATA_W+7:DATA_W];
        n_r    <= num_pts_i;
        idx    <= '0;
        err_r  <= !range_ok;
      end else if (state == ISSUE) begin
        idx <= idx + PTS_W'(1);
      end
      wd <= (state == DRAIN) ? wd + WD_W'(1) : '0;
      if (state == DRAIN && nxt == REPORT) err_r <= !dist_done_i;
      dist_start_r <= dp_rd;
      last_r       <= dp_rd && last_idx;
    end
  end

  assign tp_ready_o   = !full;
  assign fifo_cnt_o   = cnt;
  assign busy_o       = (state != IDLE);
  assign dp_rd_o      = dp_rd;
  assign dp_addr_o    = dp_rd ? idx : '0;
  assign dist_start_o = dist_start_r;
  assign dist_last_o  = last_r;
  assign dist_test_o  = dist_start_r ? test_r : '0;
  assign dist_data_o  = dist_start_r ? dp_data_i : '0;
  assign res_valid_o  = (state == REPORT);
  assign res_tag_o    = res_valid_o ? tag_r : 8'd0;
  assign res_err_o    = res_valid_o && err_r;

endmodule

// File: tb/tb_knn_batch_sched.sv
// Directed bench for knn_batch_sched: linear sequence of steps with hand-computed expectations.
// Inputs change 1ns after the rising edge; outputs are sampled at that point.
// Data-point memory responds one cycle after a read with 0xD000_0000 | address.
module tb_knn_batch_sched;
  localparam int DATA_W = 32, MAX_PTS = 16, PTS_W = 5, FIFO_DEPTH = 4, CNT_W = 3, TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              rst, en, tp_valid, tp_ready, dp_rd, dist_start, dist_last, dist_done;
  logic              res_valid, res_ready, res_err, busy;
  logic [PTS_W-1:0]  num_pts, dp_addr;
  logic [DATA_W-1:0] tp_data, dp_data, dist_test, dist_data;
  logic [7:0]        res_tag;
  logic [CNT_W-1:0]  fifo_cnt;

  int vectors = 0;
  int miscompares = 0;

  knn_batch_sched #(.DATA_W(DATA_W), .MAX_PTS(MAX_PTS), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .en_i(en), .num_pts_i(num_pts),
    .tp_valid_i(tp_valid), .tp_data_i(tp_data), .tp_ready_o(tp_ready),
    .dp_rd_o(dp_rd), .dp_addr_o(dp_addr), .dp_data_i(dp_data),
    .dist_start_o(dist_start), .dist_test_o(dist_test), .dist_data_o(dist_data), .dist_last_o(dist_last),
    .dist_done_i(dist_done),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_tag_o(res_tag), .res_err_o(res_err),
    .busy_o(busy), .fifo_cnt_o(fifo_cnt)
  );

  always #5 clk = ~clk;

  // Data-point memory model: one-cycle read latency.
  always @(posedge clk) dp_data <= dp_rd ? (32'hD000_0000 | 32'(dp_addr)) : 32'h0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] d);
    tp_valid = 1'b1;
    tp_data  = d;
    tick;
    tp_valid = 1'b0;
  endtask

  // Runs one single-point job to completion: waits for the last issue, pulses done, handshakes.
  task automatic do_job(input logic [7:0] etag, input logic [31:0] etest);
    logic        seen = 1'b0;
    logic [31:0] got = 32'h0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (dist_start && dist_last) begin
        seen = 1'b1;
        got  = dist_test;
      end else begin
        tick;
      end
    end
    chk("job_last_issue_seen", seen, 1);
    chk("job_test_point", got, etest);
    dist_done = 1'b1;
    tick;
    dist_done = 1'b0;
    chk("job_res_valid", res_valid, 1);
    chk("job_res_tag", res_tag, etag);
    chk("job_res_err", res_err, 0);
    res_ready = 1'b1;
    tick;
    res_ready = 1'b0;
  endtask

  initial begin
    int acc;
    rst = 1'b1; en = 1'b0; num_pts = '0; tp_valid = 1'b0; tp_data = '0;
    dist_done = 1'b0; res_ready = 1'b0;

    // Reset state
    tick; tick;
    chk("rst_tp_ready", tp_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_fifo_cnt", fifo_cnt, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_dp_rd", dp_rd, 0);
    chk("rst_dist_start", dist_start, 0);
    chk("rst_res_tag", res_tag, 0);
    rst = 1'b0;
    tick;

    // Basic three-point job
    push(32'h5);
    chk("b_fifo_cnt_1", fifo_cnt, 1);
    en = 1'b1; num_pts = 5'd3;
    tick;
    chk("b_rd0", dp_rd, 1);
    chk("b_addr0", dp_addr, 0);
    chk("b_fifo_cnt_0", fifo_cnt, 0);
    chk("b_busy", busy, 1);
    chk("b_start_c0", dist_start, 0);
    tick;
    chk("b_addr1", dp_addr, 1);
    chk("b_start_c1", dist_start, 1);
    chk("b_data_c1", dist_data, 32'hD000_0000);
    chk("b_test_c1", dist_test, 32'h5);
    chk("b_last_c1", dist_last, 0);
    tick;
    chk("b_addr2", dp_addr, 2);
    chk("b_data_c2", dist_data, 32'hD000_0001);
    chk("b_last_c2", dist_last, 0);
    tick;
    chk("b_rd_off", dp_rd, 0);
    chk("b_start_c3", dist_start, 1);
    chk("b_last_c3", dist_last, 1);
    chk("b_data_c3", dist_data, 32'hD000_0002);
    en = 1'b0;
    tick;
    chk("b_start_off", dist_start, 0);
    chk("b_data_zero", dist_data, 0);
    chk("b_test_zero", dist_test, 0);
    chk("b_no_res_yet", res_valid, 0);
    dist_done = 1'b1;
    tick;
    dist_done = 1'b0;
    chk("b_res_valid", res_valid, 1);
    chk("b_res_tag", res_tag, 0);
    chk("b_res_err", res_err, 0);
    res_ready = 1'b1;
    tick;
    res_ready = 1'b0;
    chk("b_res_dropped", res_valid, 0);
    chk("b_idle", busy, 0);

    // Stray done in IDLE
    dist_done = 1'b1;
    tick;
    dist_done = 1'b0;
    chk("stray_idle_busy", busy, 0);
    chk("stray_idle_res", res_valid, 0);

    // Queue fill with en low, then drain four jobs plus the held fifth push
    rst = 1'b1;
    tick;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("q_ready_before_push", tp_ready, 1);
      push(32'h100 + i);
    end
    chk("q_fifo_full_cnt", fifo_cnt, 4);
    chk("q_ready_low", tp_ready, 0);
    tp_valid = 1'b1; tp_data = 32'h104;
    tick;
    chk("q_no_accept_full", fifo_cnt, 4);
    chk("q_en_low_idle", busy, 0);
    en = 1'b1; num_pts = 5'd1;
    tick;
    chk("q_pop_cnt", fifo_cnt, 3);
    chk("q_ready_back", tp_ready, 1);
    tick;
    tp_valid = 1'b0;
    chk("q_fifth_accepted", fifo_cnt, 4);
    for (int i = 0; i < 5; i++) do_job(8'(i), 32'h100 + i);

    // Out-of-range point counts
    num_pts = 5'd0;
    push(32'h200);
    tick;
    chk("z_res_valid", res_valid, 1);
    chk("z_res_err", res_err, 1);
    chk("z_res_tag", res_tag, 5);
    chk("z_no_rd", dp_rd, 0);
    res_ready = 1'b1; tick; res_ready = 1'b0;
    num_pts = 5'd17;
    push(32'h201);
    chk("o_no_rd_idle", dp_rd, 0);
    tick;
    chk("o_res_valid", res_valid, 1);
    chk("o_res_err", res_err, 1);
    chk("o_res_tag", res_tag, 6);
    chk("o_no_start", dist_start, 0);
    res_ready = 1'b1; tick; res_ready = 1'b0;

    // Drain watchdog
    num_pts = 5'd2;
    push(32'h300);
    tick;
    chk("t_addr0", dp_addr, 0);
    chk("t_rd0", dp_rd, 1);
    tick;
    chk("t_addr1", dp_addr, 1);
    tick;
    chk("t_drain_last", dist_last, 1);
    chk("t_drain_busy", busy, 1);
    chk("t_drain_no_res", res_valid, 0);
    repeat (TIMEOUT - 1) tick;
    chk("t_before_timeout", res_valid, 0);
    tick;
    chk("t_timeout_res", res_valid, 1);
    chk("t_timeout_err", res_err, 1);
    chk("t_timeout_tag", res_tag, 7);
    dist_done = 1'b1;
    tick;
    dist_done = 1'b0;
    chk("t_stray_report_valid", res_valid, 1);
    chk("t_stray_report_err", res_err, 1);

    // Held REPORT with a queued point, then reset mid-ISSUE
    push(32'h400);
    for (int i = 0; i < 10; i++) begin
      chk("h_valid", res_valid, 1);
      chk("h_tag", res_tag, 7);
      chk("h_err", res_err, 1);
      chk("h_no_new_job", fifo_cnt, 1);
      tick;
    end
    res_ready = 1'b1;
    tick;
    res_ready = 1'b0;
    chk("h_idle_gap", busy, 0);
    chk("h_idle_cnt", fifo_cnt, 1);
    tick;
    chk("h_b2b_rd", dp_rd, 1);
    chk("h_b2b_addr", dp_addr, 0);
    chk("h_b2b_cnt", fifo_cnt, 0);
    tick;
    chk("h_mid_addr", dp_addr, 1);
    rst = 1'b1;
    #1;
    chk("r_dp_rd", dp_rd, 0);
    chk("r_dist_start", dist_start, 0);
    chk("r_busy", busy, 0);
    chk("r_fifo_cnt", fifo_cnt, 0);
    chk("r_tp_ready", tp_ready, 1);
    chk("r_res_valid", res_valid, 0);
    tick;
    rst = 1'b0;
    num_pts = 5'd1;
    push(32'h500);
    do_job(8'd0, 32'h500);

    // Tag wrap: 254 fast error jobs take tags 1..254, then 255 and 0
    num_pts = 5'd0;
    res_ready = 1'b1;
    tp_data = 32'h600;
    tp_valid = 1'b1;
    acc = 0;
    for (int c = 0; c < 3000 && acc < 254; c++) begin
      if (tp_ready) acc++;
      tick;
    end
    tp_valid = 1'b0;
    chk("w_accepted", acc, 254);
    for (int i = 0; i < 100 && (busy || fifo_cnt != 0); i++) tick;
    chk("w_settled_busy", busy, 0);
    chk("w_settled_cnt", fifo_cnt, 0);
    res_ready = 1'b0;
    num_pts = 5'd1;
    push(32'h7FF);
    do_job(8'd255, 32'h7FF);
    push(32'h800);
    do_job(8'd0, 32'h800);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/knn_batch_sched.md
KNN_BATCH_SCHED -- requirements
Module: knn_batch_sched

Interface
REQ-001 Parameter DATA_W, 32, width of test/data points.
REQ-002 Parameter MAX_PTS, 16, maximum data points per job; PTS_W = clog2(MAX_PTS+1).
REQ-003 Parameter FIFO_DEPTH, 4, test-point queue depth (power of 2).
REQ-004 Parameter TIMEOUT, 64, DRAIN watchdog limit in cycles.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  clock; all state on rising edge.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 en_i  in  1  permit start of new jobs.
REQ-009 num_pts_i  in  PTS_W  data points per job, sampled at job start.
REQ-010 tp_valid_i / tp_data_i / tp_ready_o  in/in/out  1/DATA_W/1  test-point push handshake.
REQ-011 dp_rd_o / dp_addr_o / dp_data_i  out/out/in  1/PTS_W/DATA_W  data-point memory read; data valid one cycle after dp_rd_o.
REQ-012 dist_start_o / dist_test_o / dist_data_o / dist_last_o  out  1/DATA_W/DATA_W/1  issue to distance datapath.
REQ-013 dist_done_i  in  1  one-cycle pulse from datapath: job result ready.
REQ-014 res_valid_o / res_ready_i / res_tag_o / res_err_o  out/in/out/out  1/1/8/1  job-completion handshake.
REQ-015 busy_o  out  1  state != IDLE; fifo_cnt_o  out  clog2(FIFO_DEPTH)+1  queue occupancy.

Function
REQ-016 FIFO entries hold {tag[7:0], test point}; push when tp_valid_i && tp_ready_o; tp_ready_o = !full (no bypass; pop and push same cycle both take effect).
REQ-017 Tag counter starts 0, increments by 1 per accepted push, wraps 255->0.
REQ-018 States: IDLE, ISSUE, DRAIN, REPORT; single-hot or encoded at implementer's choice.
REQ-019 IDLE: if en_i && FIFO non-empty, pop head into test/tag registers, latch num_pts_i, clear index; go ISSUE if 1<=num_pts_i<=MAX_PTS, else go REPORT with err=1 (no reads, no issues).
REQ-020 ISSUE: exactly N=latched count cycles; each cycle dp_rd_o=1, dp_addr_o=index (0..N-1), index++; after cycle N-1 go DRAIN.
REQ-021 dist_start_o is dp_rd_o delayed one cycle (registered); dist_data_o = dp_data_i while dist_start_o=1, else 0; dist_test_o = latched test point while dist_start_o=1, else 0.
REQ-022 dist_last_o = 1 only with the issue carrying index N-1 (first DRAIN cycle).
REQ-023 DRAIN: watchdog counts from 0 at entry; dist_done_i (including first DRAIN cycle) -> REPORT, err=0; watchdog reaching TIMEOUT-1 without done -> REPORT, err=1.
REQ-024 dist_done_i outside DRAIN is ignored.
REQ-025 REPORT: res_valid_o=1 with stable res_tag_o/res_err_o until res_valid_o && res_ready_i; then IDLE next cycle.
REQ-026 en_i deassertion never aborts a job in progress; only blocks IDLE exit.
REQ-027 Back-to-back: IDLE with queued entry starts a new job the cycle after REPORT handshake returns to IDLE (one IDLE cycle minimum between jobs).

Reset
REQ-028 On rst: state=IDLE, FIFO empty, tag counter=0, index/watchdog=0.
REQ-029 On rst all outputs 0 except tp_ready_o=1; reset mid-job discards job and queue with no res_valid_o.

Verification
REQ-030 Push tp=0x0000_0005 (tag 0), num_pts_i=3, en_i=1 -> dp_addr_o 0,1,2 on 3 consecutive cycles; dist_start_o 3 cycles one later, dist_last_o on third; done -> res_valid_o, tag=0, err=0.
REQ-031 Push 5 points with en_i=0 -> tp_ready_o drops after 4th accept, fifo_cnt_o=4; en_i=1 -> 4 jobs complete with tags 0,1,2,3, then 5th accepted with tag 4.
REQ-032 num_pts_i=0 and num_pts_i=MAX_PTS+1 -> no dp_rd_o, res_valid_o with err=1.
REQ-033 No dist_done_i after ISSUE -> res_valid_o with err=1 exactly TIMEOUT cycles after DRAIN entry; stray done in IDLE/REPORT ignored.
REQ-034 Hold res_ready_i=0 for 10 cycles -> res_valid_o/tag/err stable, no new job; assert rst mid-ISSUE -> all outputs 0, fifo_cnt_o=0, next push gets tag 0.
REQ-035 Push 256 points over time -> tag wraps 255->0.
